// File: rtl/mel_log_serializer_if.sv
// ----------------------------------------------------------------------------
// mel_log_serializer_if
//  Bundles the wide parallel filterbank frame (valid/ready) and the narrow
//  serial log2 coefficient stream (valid/ready/last) used by
//  mel_log_serializer.
//
//  Signals
//   filtered_data_in    NUM_FILTERS x IN_WIDTH  filterbank energies
//   filtered_valid_in   1                       frame valid
//   filtered_ready_out  1                       serializer can take a frame
//   log_data_out        OUT_WIDTH               {int, frac} log2 coefficient
//   log_valid_out       1                       coefficient valid
//   log_last_out        1                       final coefficient of frame
//   log_ready_in        1                       downstream accepts beat
//
//  Modports
//   slave   the serializer itself
//   master  the surrounding environment (filterbank + downstream consumer)
// ----------------------------------------------------------------------------
interface mel_log_serializer_if #(
  parameter int NUM_FILTERS = 26,
  parameter int IN_WIDTH    = 32,
  parameter int FRAC_BITS   = 11,
  parameter int OUT_WIDTH   = $clog2(IN_WIDTH) + FRAC_BITS
);

  logic [IN_WIDTH-1:0]  filtered_data_in [NUM_FILTERS];
  logic                 filtered_valid_in;
  logic                 filtered_ready_out;
  logic [OUT_WIDTH-1:0] log_data_out;
  logic                 log_valid_out;
  logic                 log_last_out;
  logic                 log_ready_in;

  modport slave (
    input  filtered_data_in,
    input  filtered_valid_in,
    output filtered_ready_out,
    output log_data_out,
    output log_valid_out,
    output log_last_out,
    input  log_ready_in
  );

  modport master (
    output filtered_data_in,
    output filtered_valid_in,
    input  filtered_ready_out,
    input  log_data_out,
    input  log_valid_out,
    input  log_last_out,
    output log_ready_in
  );

endinterface

// File: rtl/mel_log_serializer.sv
// ----------------------------------------------------------------------------
// mel_log_serializer
//  Accepts one parallel mel filterbank frame, holds it in a local buffer and
//  streams out the fixed-point log2 of each energy, one coefficient per beat,
//  with valid/ready/last. Capture and emission never overlap, so upstream may
//  change its bus freely once a frame has been taken.
//
//  Ports
//   clk_in   in  1  system clock, rising edge
//   rst_in   in  1  synchronous active-high reset
//   bus      slave modport of mel_log_serializer_if
//              filtered_data_in/valid_in/ready_out : frame input handshake
//              log_data_out/valid_out/last_out/ready_in : serial output
//
//  log2 format: {int[INT_W-1:0], frac[FRAC_BITS-1:0]} where int is the index
//  of the leading one and frac is the truncated bits just below it
//  (linear mantissa approximation). Inputs 0 and 1 both give 0.
// ----------------------------------------------------------------------------
module mel_log_serializer #(
  parameter int NUM_FILTERS = 26,
  parameter int IN_WIDTH    = 32,
  parameter int FRAC_BITS   = 11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mel_log_serializer_if.slave   bus
);

  localparam int INT_W     = $clog2(IN_WIDTH);
  localparam int OUT_WIDTH = INT_W + FRAC_BITS;
  localparam int IDX_W     = $clog2(NUM_FILTERS);
  localparam int EXT_W     = IN_WIDTH + FRAC_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 idx_is_last;
  logic [IN_WIDTH-1:0]  log_src;
  logic [OUT_WIDTH-1:0] log_val;
  logic [IN_WIDTH-1:0]  frame_buf [NUM_FILTERS];

  // Leading-one position gives the integer part. The word is padded with
  // FRAC_BITS zeros on the right and shifted so the leading one lands on the
  // top bit; the FRAC_BITS just below it are then the truncated fraction,
  // already zero-filled when fewer than FRAC_BITS bits sit below the one.
  function automatic logic [OUT_WIDTH-1:0] log2_fixed(input logic [IN_WIDTH-1:0] x);
    logic [INT_W-1:0]     msb;
    logic [EXT_W-1:0]     ext;
    logic [FRAC_BITS-1:0] frac;
    msb = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (x[i]) begin
        msb = INT_W'(i);
      end
    end
    ext  = {x, {FRAC_BITS{1'b0}}} << (INT_W'(IN_WIDTH - 1) - msb);
    frac = ext[EXT_W-2 -: FRAC_BITS];
    return {msb, frac};
  endfunction

  // One shared log2 unit: in IDLE it looks at coefficient 0 of the incoming
  // frame so that coefficient is ready on the capture edge; in EMIT it looks
  // ahead at the buffered coefficient that follows the one being presented.
  // The look-ahead index wraps to 0 on the final beat so it never leaves the
  // buffer range.
  always_comb begin
    idx_is_last = (idx == LAST_IDX);
    idx_next    = idx_is_last ? '0 : idx + IDX_W'(1);
    log_src     = (state == IDLE) ? bus.filtered_data_in[0] : frame_buf[idx_next];
    log_val     = log2_fixed(log_src);
  end

  // Frame buffer: loaded only on an accepted frame, so the raw energies stay
  // put for the whole emission regardless of what upstream drives.
  always_ff @(posedge clk_in) begin
    if (state == IDLE && bus.filtered_valid_in && bus.filtered_ready_out) begin
      frame_buf <= bus.filtered_data_in;
    end
  end

  // Control FSM with registered handshake outputs. The input ready flag is
  // kept equal to (state == IDLE) by updating it on every state transition.
  // A stalled output beat leaves data/last/idx untouched.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                  <= IDLE;
      idx                    <= '0;
      bus.log_valid_out      <= 1'b0;
      bus.log_last_out       <= 1'b0;
      bus.log_data_out       <= '0;
      bus.filtered_ready_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.filtered_valid_in && bus.filtered_ready_out) begin
            bus.log_data_out       <= log_val;
            bus.log_valid_out      <= 1'b1;
            bus.log_last_out       <= 1'b0;
            bus.filtered_ready_out <= 1'b0;
            idx                    <= '0;
            state                  <= EMIT;
          end
        end
        EMIT: begin
          if (bus.log_ready_in) begin
            if (bus.log_last_out) begin
              bus.log_valid_out      <= 1'b0;
              bus.log_last_out       <= 1'b0;
              bus.filtered_ready_out <= 1'b1;
              idx                    <= '0;
              state                  <= IDLE;
            end else begin
              bus.log_data_out <= log_val;
              bus.log_last_out <= (idx_next == LAST_IDX);
              idx              <= idx_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mel_log_serializer.sv
// ----------------------------------------------------------------------------
// tb_mel_log_serializer
//  Directed sequence of frames (fixed and random) through mel_log_serializer.
//  Expected coefficients come from an arithmetic log2 model: find the largest
//  power of two not above x, take the integer part as its exponent and the
//  fraction as (x - 2^m) * 2^FRAC_BITS / 2^m, truncated.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mel_log_serializer;

  localparam int NF = 26;
  localparam int IW = 32;
  localparam int FB = 11;
  localparam int OW = $clog2(IW) + FB;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] cur_frame  [NF];
  logic [IW-1:0] next_frame [NF];
  time           last_capture_time;
  time           t0;

  // 100 MHz clock
  always #5 clk = ~clk;

  mel_log_serializer_if #(.NUM_FILTERS(NF), .IN_WIDTH(IW), .FRAC_BITS(FB)) bus ();

  mel_log_serializer #(.NUM_FILTERS(NF), .IN_WIDTH(IW), .FRAC_BITS(FB)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Arithmetic reference for the fixed-point log2
  function automatic logic [OW-1:0] ref_log2(input logic [IW-1:0] x);
    longint v, p, frac;
    int m;
    v = {32'd0, x};
    if (v <= 1) return '0;
    p = 1;
    m = 0;
    while (p * 2 <= v) begin
      p = p * 2;
      m++;
    end
    frac = ((v - p) << FB) / p;
    return OW'((longint'(m) << FB) + frac);
  endfunction

  // One comparison point
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive next_frame onto the frame bus
  task automatic apply_stimulus(input bit valid);
    bus.filtered_data_in  = next_frame;
    bus.filtered_valid_in = valid;
  endtask

  // Random energies spread over the whole dynamic range
  task automatic randomize_next();
    for (int i = 0; i < NF; i++) begin
      next_frame[i] = $urandom() >> $urandom_range(0, 31);
    end
  endtask

  // Present next_frame until accepted; afterwards either keep presenting a
  // fresh random frame (hold_valid) or drop valid with junk on the data bus.
  task automatic capture_frame(input bit hold_valid);
    int waited = 0;
    apply_stimulus(1'b1);
    while (bus.filtered_ready_out !== 1'b1 && waited < 4 * NF) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("capture_ready", bus.filtered_ready_out, 1);
    @(posedge clk); #1;
    cur_frame         = next_frame;
    last_capture_time = $time;
    randomize_next();
    apply_stimulus(hold_valid);
  endtask

  // Consume up to max_beats coefficients of cur_frame under the chosen
  // downstream ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random.
  task automatic emit_and_check(input int ready_mode, input int max_beats, input string tag);
    int            beat = 0;
    int            cyc  = 0;
    bit            r;
    bit            stalled = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [OW-1:0] exp_q [$];
    for (int i = 0; i < NF; i++) exp_q.push_back(ref_log2(cur_frame[i]));
    while (beat < max_beats && cyc < 8 * NF + 20) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.log_ready_in = r;
      check_output({tag, "_valid"}, bus.log_valid_out, 1);
      check_output({tag, "_data"}, bus.log_data_out, exp_q[beat]);
      check_output({tag, "_last"}, bus.log_last_out, (beat == NF - 1));
      check_output({tag, "_in_ready"}, bus.filtered_ready_out, 0);
      if (stalled) begin
        check_output({tag, "_hold"}, {bus.log_last_out, bus.log_data_out},
                     {prev_last, prev_data});
      end
      prev_data = bus.log_data_out;
      prev_last = bus.log_last_out;
      stalled   = !r;
      @(posedge clk); #1;
      cyc++;
      if (r) beat++;
    end
    check_output({tag, "_beats"}, beat, max_beats);
    if (max_beats == NF) begin
      check_output({tag, "_end_valid"}, bus.log_valid_out, 0);
      check_output({tag, "_end_last"}, bus.log_last_out, 0);
      check_output({tag, "_end_in_ready"}, bus.filtered_ready_out, 1);
    end
  endtask

  // Watchdog against a wedged run
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    rst = 1'b1;
    for (int i = 0; i < NF; i++) next_frame[i] = '0;
    apply_stimulus(1'b0);
    bus.log_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid", bus.log_valid_out, 0);
    check_output("rst_last", bus.log_last_out, 0);
    check_output("rst_data", bus.log_data_out, 0);
    check_output("rst_in_ready", bus.filtered_ready_out, 1);
    rst = 1'b0;

    $display("[TB] flat frame");
    for (int i = 0; i < NF; i++) next_frame[i] = 32'h0000_BEEF;
    capture_frame(1'b0);
    emit_and_check(0, NF, "t1");

    $display("[TB] boundary values");
    for (int i = 0; i < NF; i++) next_frame[i] = '0;
    next_frame[1] = 32'd1;
    next_frame[2] = 32'd6;
    next_frame[3] = 32'h8000_0000;
    next_frame[4] = 32'hFFFF_FFFF;
    capture_frame(1'b0);
    emit_and_check(0, NF, "t2");

    $display("[TB] backpressure");
    randomize_next();
    capture_frame(1'b0);
    emit_and_check(1, NF, "t3");
    randomize_next();
    capture_frame(1'b0);
    emit_and_check(2, NF, "t3r");

    $display("[TB] frame offered during emission");
    randomize_next();
    capture_frame(1'b1);
    emit_and_check(2, NF, "t4a");
    capture_frame(1'b0);
    emit_and_check(0, NF, "t4b");

    $display("[TB] reset mid-frame");
    randomize_next();
    capture_frame(1'b0);
    emit_and_check(0, 10, "t5a");
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("t5_rst_valid", bus.log_valid_out, 0);
    check_output("t5_rst_last", bus.log_last_out, 0);
    check_output("t5_rst_data", bus.log_data_out, 0);
    check_output("t5_rst_in_ready", bus.filtered_ready_out, 1);
    rst = 1'b0;
    randomize_next();
    capture_frame(1'b0);
    emit_and_check(2, NF, "t5b");

    $display("[TB] continuous valid");
    randomize_next();
    capture_frame(1'b1);
    for (int k = 0; k < 3; k++) begin
      t0 = last_capture_time;
      emit_and_check(0, NF, "t6");
      capture_frame(1'b1);
      check_output("t6_period", 32'((last_capture_time - t0) / 10), NF + 1);
    end
    emit_and_check(0, NF, "t6_tail");
    bus.filtered_valid_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
